// File: rtl/nexus_work_sequencer_if.sv
// Signal bundle between the work sequencer, its work source, the hash core and the result consumer.
interface nexus_work_sequencer_if;
  logic          work_valid;
  logic          work_ready;
  logic [1727:0] work_pkt;
  logic [63:0]   start_nonce;
  logic [31:0]   nonce_count;
  logic [1727:0] core_work_pkt;
  logic [63:0]   core_in_nonce;
  logic          core_nHashRst;
  logic          core_good;
  logic [63:0]   core_nonce;
  logic          result_valid;
  logic          result_ready;
  logic [63:0]   result_nonce;
  logic          busy;
  logic          done;
  logic [7:0]    drop_count;

  modport master (
    output work_valid, work_pkt, start_nonce, nonce_count, core_good, core_nonce, result_ready,
    input  work_ready, core_work_pkt, core_in_nonce, core_nHashRst, result_valid, result_nonce,
           busy, done, drop_count
  );

  modport slave (
    input  work_valid, work_pkt, start_nonce, nonce_count, core_good, core_nonce, result_ready,
    output work_ready, core_work_pkt, core_in_nonce, core_nHashRst, result_valid, result_nonce,
           busy, done, drop_count
  );
endinterface

// File: rtl/nexus_work_sequencer.sv
// Sequences one nonce range through a pipelined hash core and buffers good nonces in a small result FIFO.
module nexus_work_sequencer #(
  parameter int unsigned PIPE_LATENCY = 8,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic clk,
  input  logic rst,
  nexus_work_sequencer_if.slave bus
);
  localparam int unsigned PKT_W   = 1728;
  localparam int unsigned NONCE_W = 64;
  localparam int unsigned N_W     = 32;
  localparam int unsigned WIN_W   = 33;
  localparam int unsigned DROP_W  = 8;
  localparam int unsigned AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW      = AW + 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t state, stateNext;
  logic [WIN_W-1:0] win, winNext, target, winLo;
  logic [N_W-1:0]   nReg;
  logic             accept, doneNext;

  logic               workReady, busyQ, doneQ, nHashRstQ, resultValid;
  logic [PKT_W-1:0]   corePkt;
  logic [NONCE_W-1:0] coreNonce, resultNonce;
  logic [DROP_W-1:0]  dropCount;

  logic [NONCE_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      rdPtr, wrPtr, rdPtrNext, wrPtrNext;
  logic [CW-1:0]      count, countNext, countAfterPop;
  logic               pushReq, pop, doPush, dropEvt;
  logic [NONCE_W-1:0] headNext;

  assign accept = bus.work_valid && workReady;
  assign target = WIN_W'(nReg) + WIN_W'(PIPE_LATENCY);
  assign winLo  = WIN_W'(PIPE_LATENCY) + WIN_W'(1);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      win   <= '0;
    end else begin
      state <= stateNext;
      win   <= winNext;
    end
  end

  // Next state; new work always wins and restarts at LOAD
  always_comb begin
    stateNext = state;
    winNext   = win;
    doneNext  = 1'b0;
    case (state)
      IDLE: winNext = '0;
      LOAD: begin
        if (nReg == '0) begin
          stateNext = IDLE;
        end else begin
          stateNext = RUN;
          winNext   = WIN_W'(1);
        end
      end
      RUN: begin
        if (win == target) begin
          stateNext = IDLE;
          winNext   = '0;
        end else begin
          winNext = win + WIN_W'(1);
        end
      end
      default: begin
        stateNext = IDLE;
        winNext   = '0;
      end
    endcase
    if (accept) begin
      stateNext = LOAD;
      winNext   = '0;
    end
    // done is registered, so flag the cycle that is about to meet the end condition
    doneNext = ((stateNext == RUN) && (winNext == target)) ||
               (accept && (bus.nonce_count == '0));
  end

  // Result FIFO bookkeeping; a pop frees room for a same-cycle push
  always_comb begin
    pop           = resultValid && bus.result_ready;
    pushReq       = bus.core_good && (state == RUN) && (win >= winLo) && (win <= target);
    countAfterPop = count - CW'(pop);
    dropEvt       = pushReq && (countAfterPop == CW'(FIFO_DEPTH));
    doPush        = pushReq && !dropEvt;
    rdPtrNext     = rdPtr + AW'(pop);
    wrPtrNext     = wrPtr + AW'(doPush);
    countNext     = countAfterPop + CW'(doPush);
    headNext      = (doPush && (wrPtr == rdPtrNext)) ? bus.core_nonce : mem[rdPtrNext];
  end

  // Registered outputs and FIFO control
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      workReady   <= 1'b0;
      busyQ       <= 1'b0;
      nHashRstQ   <= 1'b0;
      doneQ       <= 1'b0;
      corePkt     <= '0;
      coreNonce   <= '0;
      nReg        <= '0;
      rdPtr       <= '0;
      wrPtr       <= '0;
      count       <= '0;
      resultValid <= 1'b0;
      resultNonce <= '0;
      dropCount   <= '0;
    end else begin
      workReady <= (stateNext != LOAD);
      busyQ     <= (stateNext != IDLE);
      nHashRstQ <= (stateNext == RUN);
      doneQ     <= doneNext;
      if (accept) begin
        corePkt   <= bus.work_pkt;
        coreNonce <= bus.start_nonce;
        nReg      <= bus.nonce_count;
      end
      rdPtr       <= rdPtrNext;
      wrPtr       <= wrPtrNext;
      count       <= countNext;
      resultValid <= (countNext != '0);
      if (countNext != '0) resultNonce <= headNext;
      if (dropEvt && (dropCount != '1)) dropCount <= dropCount + DROP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= bus.core_nonce;
  end

  assign bus.work_ready    = workReady;
  assign bus.busy          = busyQ;
  assign bus.core_nHashRst = nHashRstQ;
  assign bus.done          = doneQ;
  assign bus.core_work_pkt = corePkt;
  assign bus.core_in_nonce = coreNonce;
  assign bus.result_valid  = resultValid;
  assign bus.result_nonce  = resultNonce;
  assign bus.drop_count    = dropCount;
endmodule

// File: doc/nexus_work_sequencer.md
NEXUS_WORK_SEQUENCER -- requirements
Module: nexus_work_sequencer

Interface
REQ-001 Parameter PIPE_LATENCY, default 8: hash-core result latency in cycles; 8 is the simulation default, and the integration value is the core's total stage count.
REQ-002 Parameter FIFO_DEPTH, default 4: result FIFO entries; must be a power of two, at least 2.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 work_valid  input  1  new work offered.
REQ-006 work_ready  output  1  work accepted when valid and ready are both high in the same cycle.
REQ-007 work_pkt  input  1728  midstate and header-tail packet.
REQ-008 start_nonce  input  64  first nonce of the range.
REQ-009 nonce_count  input  32  number of run cycles (N).
REQ-010 core_work_pkt  output  1728  registered copy of work_pkt, driven to the core.
REQ-011 core_in_nonce  output  64  registered copy of start_nonce, driven to the core.
REQ-012 core_nHashRst  output  1  core reset, active-low.
REQ-013 core_good  input  1  core good-nonce strobe.
REQ-014 core_nonce  input  64  nonce returned by the core.
REQ-015 result_valid  output  1  FIFO not empty.
REQ-016 result_ready  input  1  consumer pops the FIFO head when valid and ready are both high.
REQ-017 result_nonce  output  64  FIFO head entry.
REQ-018 busy  output  1  high when state is not IDLE.
REQ-019 done  output  1  one-cycle pulse when a range completes.
REQ-020 drop_count  output  8  results lost to a full FIFO; saturates at 255.

Function
REQ-021 The FSM SHALL have exactly three states: IDLE, LOAD and RUN.
REQ-022 work_ready SHALL be 1 in IDLE and RUN and 0 in LOAD.
REQ-023 Acceptance of work in any state SHALL latch work_pkt, start_nonce and N, and SHALL move the FSM to LOAD on the next cycle.
REQ-024 core_nHashRst SHALL be 0 in IDLE and LOAD and 1 in RUN.
REQ-025 A window counter W (33 bits) SHALL be 0 in the LOAD cycle and SHALL increment by 1 every subsequent RUN cycle.
REQ-026 In RUN, when W equals N+PIPE_LATENCY (computed in 33 bits, no wrap), the FSM SHALL pulse done for that cycle and go to IDLE.
REQ-027 If N=0, LOAD SHALL go straight to IDLE with a done pulse and no RUN cycles.
REQ-028 core_good SHALL be pushed into the FIFO only in RUN and only when PIPE_LATENCY+1 <= W <= PIPE_LATENCY+N; at all other times it SHALL be ignored (stale or out-of-range results).
REQ-029 Work accepted during RUN (preemption) SHALL restart the sequence at LOAD with W=0, SHALL suppress done for the old range, and SHALL leave the FIFO contents intact.
REQ-030 When work is accepted in the same cycle as the done condition, done SHALL still pulse and the next state SHALL be LOAD.
REQ-031 A push to a full FIFO SHALL be dropped and drop_count SHALL increment, saturating at 255.
REQ-032 A simultaneous push and pop on a full FIFO SHALL accept the push with no drop.
REQ-033 A simultaneous push and pop on an empty FIFO SHALL push only, with result_valid rising on the next cycle.
REQ-034 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-035 result_nonce SHALL hold its value while result_valid=1 and result_ready=0.
REQ-036 All outputs SHALL be registered.

Reset
REQ-037 While rst is high, the block SHALL be in IDLE with core_nHashRst=0, work_ready=0, busy=0, done=0, result_valid=0, drop_count=0, W=0, FIFO empty, and core_work_pkt and core_in_nonce at 0.
REQ-038 Assertion of rst mid-RUN SHALL discard the range and the FIFO contents immediately.
REQ-039 work_ready SHALL rise on the first clk edge after rst deasserts.

Verification
REQ-040 With PIPE_LATENCY=8, accept N=4 and start_nonce=0x100, then pulse core_good at every W from 8 to 13 -> exactly 4 entries are pushed (W=9..12), done pulses at W=12, then IDLE.
REQ-041 With N=0 accepted -> LOAD for 1 cycle, done pulses, core_nHashRst never rises, FIFO stays empty.
REQ-042 With result_ready=0 and 6 in-window core_good pulses (nonces 1..6) -> FIFO holds 1..4, drop_count=2; a subsequent pop plus push while full -> drop_count stays 2.
REQ-043 New work offered at W=5 of an N=100 range -> LOAD next cycle, W resets to 0, no done for the old range, existing FIFO entries are preserved and popped in order.
REQ-044 rst asserted mid-RUN with 3 FIFO entries -> result_valid=0, busy=0 and core_nHashRst=0 immediately; after deassertion, work_ready=1 on the next edge.
REQ-045 300 dropped pushes -> drop_count reads 255.
